// File: rtl/fullchip_pkg.sv
// Shared encodings for the fullchip host-side driver: command opcodes, inst
// word field positions, sequencer states and the inst strobe bundle.
package fullchip_pkg;

   localparam int INST_W       = 17;
   localparam int OFIFO_RD_BIT = 0;
   localparam int EXECUTE_BIT  = 1;
   localparam int LOAD_BIT     = 2;
   localparam int KMEM_WR_BIT  = 3;
   localparam int KMEM_RD_BIT  = 4;
   localparam int QMEM_WR_BIT  = 5;
   localparam int QMEM_RD_BIT  = 6;
   localparam int KMEM_ADD_LSB = 7;
   localparam int QMEM_ADD_LSB = 11;

   typedef enum logic [1:0] {
      OP_WR_Q = 2'd0,
      OP_WR_K = 2'd1,
      OP_EXEC = 2'd2,
      OP_READ = 2'd3
   } cmd_op_t;

   typedef enum logic [2:0] {
      ST_IDLE, ST_WR, ST_LOAD, ST_GAP, ST_EXEC, ST_DRAIN, ST_READ, ST_FIN
   } state_t;

   typedef struct packed {
      logic qmem_rd;
      logic qmem_wr;
      logic kmem_rd;
      logic kmem_wr;
      logic load;
      logic execute;
      logic ofifo_rd;
   } strobe_t;

endpackage

// File: rtl/fullchip_inst_enc.sv
// Combinational packer: strobe set plus K/Q addresses -> 17-bit fullchip inst
// word. Reserved bits [16:15] are always zero.
module fullchip_inst_enc
   import fullchip_pkg::*;
#(
   parameter int AW = 4
) (
   input  strobe_t           strobe,
   input  logic [AW-1:0]     kmem_add,
   input  logic [AW-1:0]     qmem_add,
   output logic [INST_W-1:0] inst
);

   always_comb begin
      inst                        = '0;
      inst[OFIFO_RD_BIT]          = strobe.ofifo_rd;
      inst[EXECUTE_BIT]           = strobe.execute;
      inst[LOAD_BIT]              = strobe.load;
      inst[KMEM_WR_BIT]           = strobe.kmem_wr;
      inst[KMEM_RD_BIT]           = strobe.kmem_rd;
      inst[QMEM_WR_BIT]           = strobe.qmem_wr;
      inst[QMEM_RD_BIT]           = strobe.qmem_rd;
      inst[KMEM_ADD_LSB +: AW]    = kmem_add;
      inst[QMEM_ADD_LSB +: AW]    = qmem_add;
   end

endmodule

// File: rtl/fullchip_driver.sv
// Host-side sequencer expanding WR_Q/WR_K/EXEC/READ commands into registered
// inst/mem_in sequences for fullchip. Option: FULLCHIP_DRIVER_STALL_CNT_EN.
module fullchip_driver
   import fullchip_pkg::*;
#(
   parameter int bw       = 8,
   parameter int pr       = 8,
   parameter int col      = 8,
   parameter int AW       = 4,
   parameter int PIPE_LAT = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [1:0]        cmd_op,
   input  logic [AW:0]       cmd_len,
   input  logic              data_valid,
   output logic              data_ready,
   input  logic [pr*bw-1:0]  data_in,
   output logic [INST_W-1:0] inst,
   output logic [pr*bw-1:0]  mem_in,
   output logic              done,
   output logic [15:0]       stall_cnt
);

   localparam int          CW         = AW + 1;
   localparam logic [AW:0] DEPTH_L    = {1'b1, {AW{1'b0}}};
   localparam logic [AW:0] COL_LAST   = CW'(col - 1);
   localparam logic [AW:0] DRAIN_LAST = CW'(PIPE_LAT - 1);

   state_t              state, state_nxt;
   logic [AW:0]         cnt, cnt_nxt;
   logic [AW:0]         len_q, len_nxt;
   logic                wr_k_q;
   logic                accept;
   logic                mem_load;
   strobe_t             strb;
   logic [AW-1:0]       kadd, qadd;
   logic [INST_W-1:0]   inst_nxt;

   assign cmd_ready  = (state == ST_IDLE);
   assign data_ready = (state == ST_WR);
   assign accept     = cmd_valid & cmd_ready;

   // Next state and the inst word for the cycle being entered, so every
   // word lands in the inst register one cycle after its triggering event.
   always_comb begin
      // NOTE: every output gets a default first so no latch is inferred.
      state_nxt = state;
      cnt_nxt   = cnt;
      len_nxt   = len_q;
      strb      = '0;
      kadd      = '0;
      qadd      = '0;
      mem_load  = 1'b0;
      case (state)
         ST_IDLE: if (accept) begin
            len_nxt = (cmd_len > DEPTH_L) ? DEPTH_L : cmd_len;
            cnt_nxt = '0;
            if (len_nxt == '0) state_nxt = ST_FIN;
            else begin
               case (cmd_op)
                  OP_WR_Q, OP_WR_K: state_nxt = ST_WR;
                  OP_EXEC: begin
                     state_nxt    = ST_LOAD;
                     strb.kmem_rd = 1'b1;
                     strb.load    = 1'b1;
                  end
                  default: begin
                     state_nxt     = ST_READ;
                     strb.ofifo_rd = 1'b1;
                  end
               endcase
            end
         end
         ST_WR: if (data_valid) begin
            mem_load = 1'b1;
            if (wr_k_q) begin
               strb.kmem_wr = 1'b1;
               kadd         = cnt[AW-1:0];
            end else begin
               strb.qmem_wr = 1'b1;
               qadd         = cnt[AW-1:0];
            end
            if (cnt == len_q - 1'b1) state_nxt = ST_FIN;
            else                     cnt_nxt   = cnt + 1'b1;
         end
         ST_LOAD: begin
            if (cnt == COL_LAST) begin
               state_nxt = ST_GAP;
               cnt_nxt   = '0;
            end else begin
               cnt_nxt      = cnt + 1'b1;
               strb.kmem_rd = 1'b1;
               strb.load    = 1'b1;
               kadd         = cnt_nxt[AW-1:0];
            end
         end
         ST_GAP: begin
            state_nxt    = ST_EXEC;
            cnt_nxt      = '0;
            strb.qmem_rd = 1'b1;
            strb.execute = 1'b1;
         end
         ST_EXEC: begin
            if (cnt == len_q - 1'b1) begin
               state_nxt = ST_DRAIN;
               cnt_nxt   = '0;
            end else begin
               cnt_nxt      = cnt + 1'b1;
               strb.qmem_rd = 1'b1;
               strb.execute = 1'b1;
               qadd         = cnt_nxt[AW-1:0];
            end
         end
         ST_DRAIN: begin
            if (cnt == DRAIN_LAST) state_nxt = ST_FIN;
            else                   cnt_nxt   = cnt + 1'b1;
         end
         ST_READ: begin
            if (cnt == len_q - 1'b1) state_nxt = ST_FIN;
            else begin
               cnt_nxt       = cnt + 1'b1;
               strb.ofifo_rd = 1'b1;
            end
         end
         ST_FIN:  state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   fullchip_inst_enc #(.AW(AW)) u_inst_enc (
      .strobe   (strb),
      .kmem_add (kadd),
      .qmem_add (qadd),
      .inst     (inst_nxt)
   );

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state  <= ST_IDLE;
         cnt    <= '0;
         len_q  <= '0;
         wr_k_q <= 1'b0;
         inst   <= '0;
         mem_in <= '0;
         done   <= 1'b0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         len_q <= len_nxt;
         if (accept)   wr_k_q <= (cmd_op == OP_WR_K);
         inst  <= inst_nxt;
         if (mem_load) mem_in <= data_in;
         done  <= (state_nxt == ST_FIN);
      end
   end

`ifdef FULLCHIP_DRIVER_STALL_CNT_EN
   logic [15:0] stall_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset)                                                     stall_q <= '0;
      else if (state == ST_WR && !data_valid && stall_q != 16'hFFFF) stall_q <= stall_q + 1'b1;
   end

   assign stall_cnt = stall_q;
`else
   assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_fullchip_driver.sv
// Directed self-checking bench for fullchip_driver; expected inst/mem_in
// values are hand-computed from the inst field map.
module tb_fullchip_driver;
   import fullchip_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [1:0]  cmd_op;
   logic [4:0]  cmd_len;
   logic        data_valid;
   logic        data_ready;
   logic [63:0] data_in;
   logic [16:0] inst;
   logic [63:0] mem_in;
   logic        done;
   logic [15:0] stall_cnt;

   int n_checks = 0;
   int n_fail   = 0;

   fullchip_driver dut (
      .clk        (clk),
      .reset      (reset),
      .cmd_valid  (cmd_valid),
      .cmd_ready  (cmd_ready),
      .cmd_op     (cmd_op),
      .cmd_len    (cmd_len),
      .data_valid (data_valid),
      .data_ready (data_ready),
      .data_in    (data_in),
      .inst       (inst),
      .mem_in     (mem_in),
      .done       (done),
      .stall_cnt  (stall_cnt)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Offers a command on the next negedge; returns at the negedge one cycle
   // after the accepting posedge (cycle 1 after accept).
   task automatic issue(input logic [1:0] op, input logic [4:0] len);
      @(negedge clk);
      check("cmd_ready_idle", cmd_ready, 1);
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_len   = len;
      @(negedge clk);
      cmd_valid = 1'b0;
   endtask

   logic [63:0] dq [3];
   logic [63:0] dk [2];
   logic [15:0] stall_exp;
   int          cnt;
   int          bad;

   initial begin
      dq[0] = 64'h0102_0304_0506_0708;
      dq[1] = 64'h1112_1314_1516_1718;
      dq[2] = 64'hA1A2_A3A4_A5A6_A7A8;
      dk[0] = 64'hDEAD_BEEF_0000_0001;
      dk[1] = 64'hCAFE_F00D_0000_0002;
`ifdef FULLCHIP_DRIVER_STALL_CNT_EN
      stall_exp = 16'd2;
`else
      stall_exp = 16'd0;
`endif

      reset = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_len = '0;
      data_valid = 1'b0; data_in = '0;
      repeat (2) @(negedge clk);
      check("rst_inst", inst, 0);
      check("rst_mem_in", mem_in, 0);
      check("rst_done", done, 0);
      check("rst_stall", stall_cnt, 0);
      check("rst_data_ready", data_ready, 0);
      reset = 1'b0;

      // WR_Q len=3, data always valid
      issue(OP_WR_Q, 5'd3);
      check("wrq_data_ready", data_ready, 1);
      for (int i = 0; i < 3; i++) begin
         data_valid = 1'b1;
         data_in    = dq[i];
         @(negedge clk);
         check("wrq_inst", inst, 64'h20 | (64'(i) << 11));
         check("wrq_mem_in", mem_in, dq[i]);
      end
      data_valid = 1'b0;
      check("wrq_done", done, 1);

      // WR_K len=2 with a two-cycle data gap
      issue(OP_WR_K, 5'd2);
      data_valid = 1'b1; data_in = dk[0];
      @(negedge clk);
      check("wrk_inst0", inst, 64'h08);
      check("wrk_mem0", mem_in, dk[0]);
      data_valid = 1'b0; data_in = 64'hFFFF_FFFF_FFFF_FFFF;
      @(negedge clk);
      check("wrk_gap_inst", inst, 0);
      check("wrk_gap_done", done, 0);
      @(negedge clk);
      check("wrk_gap_inst", inst, 0);
      check("wrk_gap_mem_hold", mem_in, dk[0]);
      data_valid = 1'b1; data_in = dk[1];
      @(negedge clk);
      data_valid = 1'b0;
      check("wrk_inst1", inst, 64'h88);
      check("wrk_mem1", mem_in, dk[1]);
      check("wrk_done", done, 1);
      check("wrk_stall_cnt", stall_cnt, stall_exp);

      // EXEC len=4
      issue(OP_EXEC, 5'd4);
      for (int i = 0; i < 8; i++) begin
         check("exec_load_inst", inst, 64'h14 | (64'(i) << 7));
         check("exec_cmd_ready", cmd_ready, 0);
         @(negedge clk);
      end
      check("exec_gap_inst", inst, 0);
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         check("exec_run_inst", inst, 64'h42 | (64'(i) << 11));
         @(negedge clk);
      end
      for (int i = 0; i < 4; i++) begin
         check("exec_drain_inst", inst, 0);
         check("exec_drain_done", done, 0);
         @(negedge clk);
      end
      check("exec_done", done, 1);
      @(negedge clk);
      check("exec_done_pulse", done, 0);
      check("exec_back_idle", cmd_ready, 1);

      // READ len=8; data_valid outside WR must be ignored
      data_valid = 1'b1; data_in = 64'h5555_5555_5555_5555;
      issue(OP_READ, 5'd8);
      for (int i = 0; i < 8; i++) begin
         check("read_inst", inst, 64'h1);
         check("read_cmd_ready", cmd_ready, 0);
         check("read_data_ready", data_ready, 0);
         @(negedge clk);
      end
      data_valid = 1'b0;
      check("read_done", done, 1);
      check("read_last_inst", inst, 0);
      check("read_mem_hold", mem_in, dk[1]);

      // cmd_len=0 is a no-op
      issue(OP_WR_Q, 5'd0);
      check("len0_done", done, 1);
      check("len0_inst", inst, 0);

      // cmd_len=31 saturates to 16
      issue(OP_READ, 5'd31);
      cnt = 0;
      for (int i = 0; i < 40 && !done; i++) begin
         if (inst == 17'h1) cnt++;
         @(negedge clk);
      end
      check("len31_done_seen", done, 1);
      check("len31_read_count", cnt, 16);

      // Reset in the middle of EXEC
      issue(OP_EXEC, 5'd4);
      repeat (4) @(negedge clk);
      reset = 1'b1;
      #1;
      check("midrst_inst", inst, 0);
      check("midrst_cmd_ready", cmd_ready, 1);
      @(negedge clk);
      reset = 1'b0;
      bad = 0;
      for (int i = 0; i < 20; i++) begin
         if (done || inst != 17'h0) bad++;
         @(negedge clk);
      end
      check("midrst_quiet", bad, 0);
      issue(OP_READ, 5'd1);
      check("post_rst_read_inst", inst, 64'h1);
      @(negedge clk);
      check("post_rst_read_done", done, 1);
      check("post_rst_read_inst_end", inst, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
